display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds the eight BCD digits, steps through digit positions at a fixed refresh rate, and drives the digit-select and value inputs of the BCD-to-seven-segment decoder. New digit sets are accepted at any time but applied only at a frame boundary, so a scan never shows half old and half new data. It sits between the stopwatch/Ethernet datapath, which produces the digits, and the decoder, which drives the `seg`/`an` pins.

## Interface
- `CLK_DIV`, 100000: clock cycles per digit slot; legal range ≥ 2.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: single-cycle request to capture `digits_in`.
- `digits_in` in 32: eight BCD nibbles; nibble *k* is `[4k+3:4k]` and drives digit position *k*.
- `v` out 4: BCD value for the current position; goes to the decoder value input.
- `anum` out 3: current digit position 0..7; goes to the decoder select input.
- `blank` out 1: 1 means the current digit must be dark; the parent forces `an` to `8'hFF` while it is set.
- `pending` out 1: a captured digit set is waiting for the next frame boundary.
- `load_ack` out 1: one-cycle pulse when a captured set becomes visible.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps. `tick` = (`pcnt` == CLK_DIV-1).
- On `tick`, `anum` increments modulo 8.
- A frame boundary is a `tick` while `anum` == 7.
- On `load`, `digits_in` is written to the shadow register and `pending` is set. A second load before the boundary overwrites the shadow register.
- At the boundary with `pending` = 1:
  - the display register takes the shadow register;
  - `pending` clears;
  - `load_ack` pulses.
- `load` in the same cycle as a boundary:
  - the old shadow value is applied;
  - the new `digits_in` goes into the shadow register;
  - `pending` stays 1;
  - `load_ack` still pulses.
- `load` at a boundary with `pending` = 0: captured only, no ack; it is applied at the next boundary.
- `v` = display nibble[`anum`], combinational from registers.
- Nibbles above 9 pass through unchanged; the decoder's default handling applies.
- Two-state scan sequencing, with the shadow-register path independent of it:
  - `SCAN`: prescaler running.
  - `APPLY`: a one-cycle `load_ack` state entered after a boundary with pending data; scanning continues during it.

## Timing
- Reset values: `pcnt`=0, `anum`=0, display=0, shadow=0, `pending`=0, `load_ack`=0, `v`=0, `blank`=0.
- `rst` mid-frame aborts immediately:
  - pending data is discarded;
  - the scan restarts at position 0 with a fresh prescaler.
- Each digit is held for exactly CLK_DIV cycles; one frame is 8×CLK_DIV cycles.
- `pending` is high from the cycle after a `load` edge.
- On the boundary edge, `anum`→0 and the display register updates together, so digit 0 of the new frame already shows the new value.
- `load_ack` is high for the single cycle after the boundary edge.
- Worst-case load-to-visible latency is 8×CLK_DIV cycles.
- `v`, `anum` and `blank` change only on `tick` edges or on an apply.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - `blank`=1 when the current position *k* ≥ 1, the nibble at *k* is 0, and every nibble above *k* is 0. For example, 00000042 shows "42".
  - Position 0 is never blanked, so all zeros shows "0".
- `LEADING_ZERO_BLANK_EN` undefined: `blank` is tied to 0 and every digit is shown.

## Test plan
All scenarios use CLK_DIV=4.
- Reset, then free-run 64 cycles:
  - `anum` follows 0,0,0,0,1,… and wraps 7→0 at cycle 32;
  - `v`=0 throughout;
  - `pending`=0 and `load_ack`=0 throughout.
- `load` with 0x87654321 at cycle 5:
  - `pending`=1 from cycle 6;
  - display updates at the cycle-31 edge;
  - `load_ack` is high in cycle 32;
  - at `anum`=0 `v`=1, and at `anum`=7 `v`=8.
- Two loads in one frame, 0x11111111 then 0x22222222 before the boundary: only 0x22222222 is displayed, with exactly one `load_ack`.
- `load` with 0x33333333 on the exact boundary cycle while 0x22222222 is pending:
  - 0x22222222 is displayed and ack'd;
  - `pending` stays 1;
  - 0x33333333 is applied one frame later, with a second ack.
- `rst` asserted mid-frame with data pending:
  - all outputs return to reset values asynchronously;
  - `pending`=0;
  - no ack follows.
- With `LEADING_ZERO_BLANK_EN`:
  - 0x00000042 gives `blank`=1 at `anum`=2..7;
  - 0x00000000 gives `blank`=0 only at `anum`=0;
  - 0x10000000 gives `blank`=0 at every position.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display with frame-aligned digit updates.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (position 0 is always shown).
module display_scan_controller #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits_in,
  output logic [3:0]  v,
  output logic [2:0]  anum,
  output logic        blank,
  output logic        pending,
  output logic        load_ack
);

  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {
    SCAN  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pcnt;
  logic [31:0]   display;
  logic [31:0]   shadow;
  logic          tick;
  logic          boundary;
  logic          apply_c;
  logic [4:0]    sh;

  assign tick     = (pcnt == PW'(CLK_DIV - 1));
  assign boundary = tick && (anum == 3'd7);
  assign apply_c  = boundary && pending;
  assign sh       = {anum, 2'b00};

  // Scan sequencing: APPLY marks the single cycle after new data became visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = SCAN;
    case (state)
      SCAN:    if (apply_c) state_nxt = APPLY;
      APPLY:   if (apply_c) state_nxt = APPLY;
      default: state_nxt = SCAN;
    endcase
  end

  assign load_ack = (state == APPLY);

  // Prescaler and digit position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      anum <= 3'd0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) anum <= anum + 3'd1;
    end
  end

  // Shadow capture is independent of the scan; the display takes the old shadow at a boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display <= 32'd0;
      shadow  <= 32'd0;
      pending <= 1'b0;
    end else begin
      if (apply_c) display <= shadow;
      if (load) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end else if (apply_c) begin
        pending <= 1'b0;
      end
    end
  end

  assign v = display[sh +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Dark when this nibble and all nibbles above it are zero, except at position 0.
  assign blank = (anum != 3'd0) && ((display >> sh) == 32'd0);
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: per-cycle scoreboard from a frame-timeline model plus table spot checks.
module tb_display_scan_controller;

  localparam int unsigned CLK_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] digits_in;
  logic [3:0]  v;
  logic [2:0]  anum;
  logic        blank;
  logic        pending;
  logic        load_ack;

  display_scan_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .v(v), .anum(anum), .blank(blank), .pending(pending), .load_ack(load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] anum;
    logic [3:0] v;
    logic       pend;
    logic       ack;
    logic       blank;
  } obs_t;

  typedef struct {
    int          ph;
    int          cyc;
    logic        ld;
    logic [31:0] data;
    logic [2:0]  anum;
    logic [3:0]  v;
    logic        pend;
    logic        ack;
    logic        blank;
  } vec_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          m_n;
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  logic        m_pend;

  function automatic vec_t mk(int ph, int cyc, logic ld, logic [31:0] d, int an, int vv,
                              logic p, logic a, logic b);
    vec_t e;
    e.ph = ph; e.cyc = cyc; e.ld = ld; e.data = d;
    e.anum = 3'(an); e.v = 4'(vv); e.pend = p; e.ack = a; e.blank = b;
    return e;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic lzb(input logic [31:0] d, input int a);
    if (!EN || a == 0) return 1'b0;
    for (int i = a; i < 8; i++)
      if (d[4*i +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic obs_t expect_now(input logic ack);
    obs_t o;
    int a;
    a = (m_n / int'(CLK_DIV)) % 8;
    o.anum  = 3'(a);
    o.v     = m_disp[4*a +: 4];
    o.pend  = m_pend;
    o.ack   = ack;
    o.blank = lzb(m_disp, a);
    return o;
  endfunction

  // Advance the model by one clock edge with the inputs driven this cycle.
  task automatic model_step(input logic ld, input logic [31:0] d);
    logic bnd;
    logic app;
    bnd = ((m_n % (8 * int'(CLK_DIV))) == (8 * int'(CLK_DIV) - 1));
    app = bnd && m_pend;
    if (app) m_disp = m_shadow;
    if (ld) begin
      m_shadow = d;
      m_pend   = 1'b1;
    end else if (app) begin
      m_pend = 1'b0;
    end
    m_n++;
    sb.push_back(expect_now(app));
  endtask

  task automatic check_out(input int c);
    obs_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", c, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("sb_anum", c, 32'(anum), 32'(e.anum));
    chk("sb_v", c, 32'(v), 32'(e.v));
    chk("sb_pending", c, 32'(pending), 32'(e.pend));
    chk("sb_load_ack", c, 32'(load_ack), 32'(e.ack));
    chk("sb_blank", c, 32'(blank), 32'(e.blank));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    digits_in = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_n = 0; m_disp = 32'd0; m_shadow = 32'd0; m_pend = 1'b0;
    sb.delete();
    sb.push_back(expect_now(1'b0));
  endtask

  task automatic run_phase(input int ph, input int len);
    logic        ld;
    logic [31:0] d;
    do_reset();
    for (int c = 0; c < len; c++) begin
      check_out(c);
      ld = 1'b0;
      d  = 32'd0;
      foreach (tbl[i]) begin
        if (tbl[i].ph == ph && tbl[i].cyc == c) begin
          chk("tbl_anum", c, 32'(anum), 32'(tbl[i].anum));
          chk("tbl_v", c, 32'(v), 32'(tbl[i].v));
          chk("tbl_pending", c, 32'(pending), 32'(tbl[i].pend));
          chk("tbl_load_ack", c, 32'(load_ack), 32'(tbl[i].ack));
          chk("tbl_blank", c, 32'(blank), 32'(tbl[i].blank & EN));
          ld = tbl[i].ld;
          d  = tbl[i].data;
        end
      end
      load = ld;
      digits_in = d;
      model_step(ld, d);
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  // Reset asserted between clock edges must clear outputs without waiting for a clock.
  task automatic mid_reset_check();
    #2 rst = 1'b1;
    #1;
    chk("async_anum", -1, 32'(anum), 32'd0);
    chk("async_v", -1, 32'(v), 32'd0);
    chk("async_pending", -1, 32'(pending), 32'd0);
    chk("async_load_ack", -1, 32'(load_ack), 32'd0);
    chk("async_blank", -1, 32'(blank), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load = 1'b0;
    digits_in = 32'd0;

    // Phase 0: free run, display all zeros.
    tbl.push_back(mk(0, 0,  0, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3,  0, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4,  0, 32'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 31, 0, 32'h0, 7, 0, 0, 0, 1));
    tbl.push_back(mk(0, 32, 0, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 63, 0, 32'h0, 7, 0, 0, 0, 1));
    // Phase 1: load, double load, load on boundary, then data pending at mid-frame reset.
    tbl.push_back(mk(1, 5,   1, 32'h87654321, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 6,   0, 32'h0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 31,  0, 32'h0, 7, 0, 1, 0, 1));
    tbl.push_back(mk(1, 32,  0, 32'h0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 33,  0, 32'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 60,  0, 32'h0, 7, 8, 0, 0, 0));
    tbl.push_back(mk(1, 70,  1, 32'h11111111, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 80,  1, 32'h22222222, 4, 5, 1, 0, 0));
    tbl.push_back(mk(1, 95,  1, 32'h33333333, 7, 8, 1, 0, 0));
    tbl.push_back(mk(1, 96,  0, 32'h0, 0, 2, 1, 1, 0));
    tbl.push_back(mk(1, 97,  0, 32'h0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 127, 0, 32'h0, 7, 2, 1, 0, 0));
    tbl.push_back(mk(1, 128, 0, 32'h0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(1, 140, 1, 32'h44444444, 3, 3, 0, 0, 0));
    tbl.push_back(mk(1, 150, 0, 32'h0, 5, 3, 1, 0, 0));
    // Phase 2: after the mid-frame reset, no ack and nothing pending.
    tbl.push_back(mk(2, 0,  0, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 32, 0, 32'h0, 0, 0, 0, 0, 0));
    // Phase 3: leading-zero blanking patterns.
    tbl.push_back(mk(3, 0,   1, 32'h00000042, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 32,  0, 32'h0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(3, 36,  0, 32'h0, 1, 4, 0, 0, 0));
    tbl.push_back(mk(3, 40,  1, 32'h00000000, 2, 0, 0, 0, 1));
    tbl.push_back(mk(3, 60,  0, 32'h0, 7, 0, 1, 0, 1));
    tbl.push_back(mk(3, 64,  0, 32'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(3, 68,  0, 32'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3, 70,  1, 32'h10000000, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3, 96,  0, 32'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(3, 100, 0, 32'h0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3, 124, 0, 32'h0, 7, 1, 0, 0, 0));

    @(negedge clk);
    run_phase(0, 64);
    run_phase(1, 151);
    mid_reset_check();
    run_phase(2, 40);
    run_phase(3, 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
